// File: rtl/debounce_bank.sv
// debounce_bank
//   Multi-channel push-button conditioner. Every channel synchronises its raw
//   button, debounces press and release symmetrically against one shared
//   sample tick, and produces a clean level, one-clk press/release strobes
//   and an optional auto-repeat strobe while the key stays held.
//
// Ports
//   clk            system clock, all logic on posedge
//   rst            synchronous, active-high reset
//   button         raw asynchronous buttons, active-high
//   level          debounced button state
//   press          one-clk strobe on each debounced 0->1
//   release_pulse  one-clk strobe on each debounced 1->0
//   repeat_pulse   one-clk auto-repeat strobe while held
//                  ("release" and "repeat" are reserved words, hence the suffix)
//   rpt_state      repeat FSM state per channel, 2 bits each
//                  (channel i at [2*i +: 2]; 0 IDLE, 1 DELAY, 2 RPT),
//                  all zero when auto-repeat is disabled
module debounce_bank #(
    parameter int CHANNELS     = 4,
    parameter int TICK_DIV     = 100000,
    parameter int THRESHOLD    = 10,
    parameter int REPEAT_EN    = 1,
    parameter int REPEAT_DELAY = 300,
    parameter int REPEAT_RATE  = 100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CHANNELS-1:0]   button,
    output logic [CHANNELS-1:0]   level,
    output logic [CHANNELS-1:0]   press,
    output logic [CHANNELS-1:0]   release_pulse,
    output logic [CHANNELS-1:0]   repeat_pulse,
    output logic [2*CHANNELS-1:0] rpt_state
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    localparam int CNT_W = (THRESHOLD > 1) ? $clog2(THRESHOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(THRESHOLD - 1);

    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RCNT_W = (RMAX > 1) ? $clog2(RMAX) : 1;
    localparam logic [RCNT_W-1:0] DELAY_LAST = RCNT_W'(REPEAT_DELAY - 1);
    localparam logic [RCNT_W-1:0] RATE_LAST  = RCNT_W'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RPT   = 2'd2
    } rpt_state_e;

    // Two-flop synchroniser; everything downstream looks at sync2 only.
    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
        end
    end

    // Shared prescaler. With TICK_DIV == 1 the count sits at 0 and tick is
    // permanently high.
    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // Combinational "level flips on this edge" events; the registered
    // strobes and the repeat FSM both key off these so press/release and
    // the FSM transition land on the same edge as the level change.
    logic [CHANNELS-1:0] press_evt;
    logic [CHANNELS-1:0] rel_evt;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic             level_q;
        logic             press_q;
        logic             rel_q;
        logic             flip;

        assign flip         = tick && (sync2[i] != level_q) && (cnt == CNT_LAST);
        assign press_evt[i] = flip && !level_q;
        assign rel_evt[i]   = flip &&  level_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt     <= '0;
                level_q <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                press_q <= press_evt[i];
                rel_q   <= rel_evt[i];
                if (tick) begin
                    if (sync2[i] == level_q) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        level_q <= ~level_q;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end
        end

        assign level[i]         = level_q;
        assign press[i]         = press_q;
        assign release_pulse[i] = rel_q;

        if (REPEAT_EN != 0) begin : g_rpt
            rpt_state_e        state;
            logic [RCNT_W-1:0] rcnt;
            logic              rpt_q;

            // The press edge only arms DELAY; counting starts on the next
            // tick, so the press tick is not part of REPEAT_DELAY.
            always_ff @(posedge clk) begin
                if (rst) begin
                    state <= IDLE;
                    rcnt  <= '0;
                    rpt_q <= 1'b0;
                end else begin
                    rpt_q <= 1'b0;
                    if (rel_evt[i]) begin
                        // Release wins over a repeat due on the same tick.
                        state <= IDLE;
                        rcnt  <= '0;
                    end else begin
                        case (state)
                            IDLE: begin
                                if (press_evt[i]) begin
                                    state <= DELAY;
                                    rcnt  <= '0;
                                end
                            end
                            DELAY: begin
                                if (tick) begin
                                    if (rcnt == DELAY_LAST) begin
                                        rpt_q <= 1'b1;
                                        state <= RPT;
                                        rcnt  <= '0;
                                    end else begin
                                        rcnt <= rcnt + 1'b1;
                                    end
                                end
                            end
                            RPT: begin
                                if (tick) begin
                                    if (rcnt == RATE_LAST) begin
                                        rpt_q <= 1'b1;
                                        rcnt  <= '0;
                                    end else begin
                                        rcnt <= rcnt + 1'b1;
                                    end
                                end
                            end
                            default: begin
                                state <= IDLE;
                                rcnt  <= '0;
                            end
                        endcase
                    end
                end
            end

            assign repeat_pulse[i]   = rpt_q;
            assign rpt_state[2*i +: 2] = state;
        end else begin : g_norpt
            assign repeat_pulse[i]   = 1'b0;
            assign rpt_state[2*i +: 2] = 2'd0;
        end
    end

endmodule

// File: tb/tb_debounce_bank.sv
// tb_debounce_bank
//   Bench for debounce_bank with CHANNELS=4, TICK_DIV=4, THRESHOLD=3,
//   REPEAT_DELAY=5, REPEAT_RATE=2. Two instances share the stimulus: one
//   with auto-repeat, one with REPEAT_EN=0. A tick-level reference model
//   predicts every output after every clock edge.
module tb_debounce_bank;

    localparam int CH = 4;
    localparam int TD = 4;
    localparam int TH = 3;
    localparam int RD = 5;
    localparam int RR = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [CH-1:0] button = '0;

    always #5 clk = ~clk;

    logic [CH-1:0]   level_a, press_a, rel_a, rep_a;
    logic [2*CH-1:0] st_a;
    logic [CH-1:0]   level_b, press_b, rel_b, rep_b;
    logic [2*CH-1:0] st_b;

    debounce_bank #(
        .CHANNELS(CH), .TICK_DIV(TD), .THRESHOLD(TH),
        .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut_a (
        .clk(clk), .rst(rst), .button(button),
        .level(level_a), .press(press_a), .release_pulse(rel_a),
        .repeat_pulse(rep_a), .rpt_state(st_a)
    );

    debounce_bank #(
        .CHANNELS(CH), .TICK_DIV(TD), .THRESHOLD(TH),
        .REPEAT_EN(0), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
    ) dut_b (
        .clk(clk), .rst(rst), .button(button),
        .level(level_b), .press(press_b), .release_pulse(rel_b),
        .repeat_pulse(rep_b), .rpt_state(st_b)
    );

    // ---------------- reference model ----------------
    // k: edges since reset released; tick_idx: ticks since reset released.
    int            k;
    int            tick_idx;
    logic [CH-1:0] b_d1, b_d2;
    logic [CH-1:0] m_lvl, m_press, m_rel, m_rep;
    logic [2*CH-1:0] m_st;
    int            streak_start [CH];
    int            press_t [CH];

    // ---------------- scoreboard state ----------------
    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int obs_press [CH];
    int obs_rel [CH];
    int obs_rep [CH];
    int obs_rep_b;
    int first_press [CH];
    int first_rep [CH];

    task automatic check(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) passed = passed + 1;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    endtask

    // Advance the model by one clock edge with the inputs seen at that edge.
    // Level changes when the last TH tick samples all disagree with it;
    // repeats fall at RD, RD+RR, RD+2*RR ... ticks after the press tick.
    task automatic model_edge(input logic r, input logic [CH-1:0] b);
        logic [CH-1:0] s;
        int d;
        m_press = '0;
        m_rel   = '0;
        m_rep   = '0;
        if (r) begin
            k = 0;
            tick_idx = 0;
            b_d1 = '0;
            b_d2 = '0;
            m_lvl = '0;
            for (int c = 0; c < CH; c++) begin
                streak_start[c] = -1;
                press_t[c] = 0;
            end
        end else begin
            k++;
            s = b_d2;
            b_d2 = b_d1;
            b_d1 = b;
            if (k % TD == 0) begin
                tick_idx++;
                for (int c = 0; c < CH; c++) begin
                    if (s[c] !== m_lvl[c]) begin
                        if (streak_start[c] < 0) streak_start[c] = tick_idx;
                        if (tick_idx - streak_start[c] + 1 >= TH) begin
                            m_lvl[c] = s[c];
                            streak_start[c] = -1;
                            if (s[c]) begin
                                m_press[c] = 1'b1;
                                press_t[c] = tick_idx;
                            end else begin
                                m_rel[c] = 1'b1;
                            end
                        end
                    end else begin
                        streak_start[c] = -1;
                    end
                    if (m_lvl[c] && !m_press[c]) begin
                        d = tick_idx - press_t[c];
                        if (d == RD || (d > RD && (d - RD) % RR == 0)) m_rep[c] = 1'b1;
                    end
                end
            end
        end
        for (int c = 0; c < CH; c++) begin
            if (!m_lvl[c]) m_st[2*c +: 2] = 2'd0;
            else if (tick_idx - press_t[c] < RD) m_st[2*c +: 2] = 2'd1;
            else m_st[2*c +: 2] = 2'd2;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_counts();
        for (int c = 0; c < CH; c++) begin
            obs_press[c] = 0;
            obs_rel[c] = 0;
            obs_rep[c] = 0;
            first_press[c] = -1;
            first_rep[c] = -1;
        end
        obs_rep_b = 0;
    endtask

    // One clock edge: capture inputs, wait for the edge, sample #1 later,
    // compare both instances against the model.
    task automatic step();
        logic r;
        logic [CH-1:0] b;
        r = rst;
        b = button;
        @(posedge clk);
        #1;
        cyc++;
        model_edge(r, b);
        check("level_a",   int'(level_a), int'(m_lvl));
        check("press_a",   int'(press_a), int'(m_press));
        check("release_a", int'(rel_a),   int'(m_rel));
        check("repeat_a",  int'(rep_a),   int'(m_rep));
        check("state_a",   int'(st_a),    int'(m_st));
        check("level_b",   int'(level_b), int'(m_lvl));
        check("press_b",   int'(press_b), int'(m_press));
        check("release_b", int'(rel_b),   int'(m_rel));
        check("repeat_b",  int'(rep_b),   0);
        for (int c = 0; c < CH; c++) begin
            obs_press[c] += int'(press_a[c]);
            obs_rel[c]   += int'(rel_a[c]);
            obs_rep[c]   += int'(rep_a[c]);
            if (press_a[c] && first_press[c] < 0) first_press[c] = cyc;
            if (rep_a[c] && first_rep[c] < 0) first_rep[c] = cyc;
        end
        obs_rep_b += int'(|rep_b);
    endtask

    // Step until the edge that carries a tick (bounded by TD edges).
    task automatic step_to_tick();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (k % TD != 0 && n < TD);
    endtask

    task automatic step_ticks(input int n);
        for (int i = 0; i < n; i++) step_to_tick();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int n;
        model_edge(1'b1, '0);
        clear_counts();

        // Reset state
        rst = 1'b1;
        button = '0;
        for (int i = 0; i < 3; i++) step();
        rst = 1'b0;

        // Clean press on ch0
        step_to_tick();
        clear_counts();
        button[0] = 1'b1;
        step_ticks(5);
        check("clean_press_cnt", obs_press[0], 1);
        check("clean_other_press", obs_press[1] + obs_press[2] + obs_press[3], 0);
        check("clean_level", int'(level_a[0]), 1);

        // Bounce on ch1, then hold
        clear_counts();
        for (int i = 0; i < 30; i++) begin
            button[1] = ((i % 6) < 3);
            step();
        end
        button[1] = 1'b1;
        check("bounce_early_press", obs_press[1], 0);
        step_ticks(6);
        check("bounce_press_cnt", obs_press[1], 1);

        // Release filtering on ch0: one-tick dip, then permanent low
        step_to_tick();
        clear_counts();
        button[0] = 1'b0;
        step_ticks(1);
        button[0] = 1'b1;
        step_ticks(4);
        check("dip_release_cnt", obs_rel[0], 0);
        check("dip_level", int'(level_a[0]), 1);
        button[0] = 1'b0;
        step_ticks(5);
        check("release_cnt", obs_rel[0], 1);
        check("release_level", int'(level_a[0]), 0);

        // Auto-repeat on ch2: release strobe lands 20 ticks after the press tick
        step_to_tick();
        clear_counts();
        button[2] = 1'b1;
        n = 0;
        while (obs_press[2] == 0 && n < 40) begin
            step();
            n++;
        end
        check("rpt_press_seen", obs_press[2], 1);
        n = 0;
        while (!(tick_idx - press_t[2] >= 17 && k % TD == 0) && n < 200) begin
            step();
            n++;
        end
        button[2] = 1'b0;
        step_ticks(6);
        check("rpt_count", obs_rep[2], 8);
        check("rpt_release_cnt", obs_rel[2], 1);
        check("rpt_disabled_cnt", obs_rep_b, 0);

        // Reset while ch3 sits in RPT
        step_to_tick();
        button[3] = 1'b1;
        n = 0;
        while (!(m_lvl[3] && tick_idx - press_t[3] > RD) && n < 30) begin
            step_to_tick();
            n++;
        end
        check("pre_reset_state3", int'(st_a[7:6]), 2);
        clear_counts();
        rst = 1'b1;
        step();
        check("in_reset_outputs", int'({level_a, press_a, rel_a, rep_a}), 0);
        step();
        rst = 1'b0;
        n = 0;
        do begin
            step();
            n++;
        end while (!press_a[3] && n < 40);
        check("repress_latency", n, 3 * TD);
        check("reset_no_release", obs_rel[0] + obs_rel[1] + obs_rel[2] + obs_rel[3], 0);
        step_ticks(RD);
        check("repress_first_rpt", obs_rep[3], 1);

        // Simultaneous ch0/ch1 rise
        button = '0;
        step_ticks(6);
        step_to_tick();
        clear_counts();
        button[1:0] = 2'b11;
        step_ticks(12);
        check("sim_press0", obs_press[0], 1);
        check("sim_press1", obs_press[1], 1);
        check("sim_press_align", first_press[1] - first_press[0], 0);
        check("sim_rpt_align", first_rep[1] - first_rep[0], 0);
        check("sim_rpt_cnt", obs_rep[0], 3);

        // Random toggling with occasional resets
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                n = $urandom_range(0, CH - 1);
                button[n] = ~button[n];
            end
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
